// File: rtl/rc_nrzi_unstuff.sv
// rtl/rc_nrzi_unstuff.sv - NRZI decoder and USB bit-unstuffer for the receive path
//
// Parameters:
//    ONES_MAX      consecutive decoded 1s after which the next bit is a stuffed bit
//    CNT_W         width of bit_count
// Ports:
//    clk           system clock
//    rst_n         asynchronous active-low reset
//    s_in          line level from the decoder (1 = J, 0 = K)
//    start_rc_nrzi pulse on the final sync K, carries no data bit
//    end_rc_nrzi   pulse marking packet end, carries no data bit
//    abort         synchronous clear, highest priority
//    out_bit       decoded, unstuffed data bit
//    out_valid     out_bit qualifier
//    pkt_end       one-cycle pulse after a normal packet end
//    bit_count     delivered bits in the current or last packet (saturating)
//    stuff_error   sticky stuffing-violation flag
module rc_nrzi_unstuff #(
   parameter int ONES_MAX = 6,
   parameter int CNT_W    = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_in,
   input  logic             start_rc_nrzi,
   input  logic             end_rc_nrzi,
   input  logic             abort,
   output logic             out_bit,
   output logic             out_valid,
   output logic             pkt_end,
   output logic [CNT_W-1:0] bit_count,
   output logic             stuff_error
);

   localparam int ONES_W = $clog2(ONES_MAX + 1);
   localparam logic [ONES_W-1:0] ONES_LIM = ONES_W'(ONES_MAX);
   localparam logic [CNT_W-1:0]  CNT_SAT  = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RX    = 2'd1,
      ERROR = 2'd2
   } state_t;

   state_t            state;
   logic              prev_level;
   logic [ONES_W-1:0] ones;
   logic              d;

   // NRZI: no level change between bit cells encodes a 1
   assign d = ~(s_in ^ prev_level);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         prev_level  <= 1'b0;
         ones        <= '0;
         bit_count   <= '0;
         out_bit     <= 1'b0;
         out_valid   <= 1'b0;
         pkt_end     <= 1'b0;
         stuff_error <= 1'b0;
      end else if (abort) begin
         state       <= IDLE;
         prev_level  <= 1'b0;
         ones        <= '0;
         bit_count   <= '0;
         out_bit     <= 1'b0;
         out_valid   <= 1'b0;
         pkt_end     <= 1'b0;
         stuff_error <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         pkt_end   <= 1'b0;
         case (state)
            IDLE: begin
               if (start_rc_nrzi) begin
                  state      <= RX;
                  prev_level <= 1'b0;   // sync pattern ends on K
                  ones       <= '0;
                  bit_count  <= '0;
               end
            end
            RX: begin
               // start outranks end when both arrive together
               if (start_rc_nrzi) begin
                  prev_level <= 1'b0;
                  ones       <= '0;
                  bit_count  <= '0;
               end else if (end_rc_nrzi) begin
                  // an owed stuffed bit at end of packet is tolerated
                  state   <= IDLE;
                  pkt_end <= 1'b1;
               end else begin
                  prev_level <= s_in;
                  if (ones < ONES_LIM) begin
                     out_bit   <= d;
                     out_valid <= 1'b1;
                     ones      <= d ? ones + 1'b1 : '0;
                     if (bit_count != CNT_SAT)
                        bit_count <= bit_count + 1'b1;
                  end else if (!d) begin
                     // stuffed zero: swallow it silently
                     ones <= '0;
                  end else begin
                     state       <= ERROR;
                     stuff_error <= 1'b1;
                  end
               end
            end
            ERROR: begin
               stuff_error <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc_nrzi_unstuff.sv
// tb/tb_rc_nrzi_unstuff.sv - self-checking bench for rc_nrzi_unstuff
module tb_rc_nrzi_unstuff;

   localparam int ONES_MAX = 6;
   localparam int CNT_W    = 7;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             s_in = 1'b0;
   logic             start_rc_nrzi = 1'b0;
   logic             end_rc_nrzi = 1'b0;
   logic             abort = 1'b0;
   logic             out_bit;
   logic             out_valid;
   logic             pkt_end;
   logic [CNT_W-1:0] bit_count;
   logic             stuff_error;

   rc_nrzi_unstuff #(.ONES_MAX(ONES_MAX), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_in          (s_in),
      .start_rc_nrzi (start_rc_nrzi),
      .end_rc_nrzi   (end_rc_nrzi),
      .abort         (abort),
      .out_bit       (out_bit),
      .out_valid     (out_valid),
      .pkt_end       (pkt_end),
      .bit_count     (bit_count),
      .stuff_error   (stuff_error)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   logic         lv [0:199];
   int           n;
   logic [199:0] got;
   int           ngot;
   bit           last_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inputs change at the falling edge; outputs of the rising edge are read at the next falling edge
   task automatic drive(input logic st, input logic en, input logic s, input logic ab);
      start_rc_nrzi = st;
      end_rc_nrzi   = en;
      s_in          = s;
      abort         = ab;
      @(negedge clk);
      start_rc_nrzi = 1'b0;
      end_rc_nrzi   = 1'b0;
      abort         = 1'b0;
   endtask

   task automatic load(input int len, input logic [199:0] bits);
      n = len;
      for (int i = 0; i < len; i++) lv[i] = bits[i];
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_bit"},   {31'd0, out_bit},     32'd0);
      check({tag, "_valid"}, {31'd0, out_valid},   32'd0);
      check({tag, "_end"},   {31'd0, pkt_end},     32'd0);
      check({tag, "_cnt"},   {25'd0, bit_count},   32'd0);
      check({tag, "_err"},   {31'd0, stuff_error}, 32'd0);
   endtask

   // Reference: decode the whole level list, then classify each decoded bit
   // as delivered / stuffed / violation from the run of delivered ones.
   task automatic run_packet(input bit both, input bit do_end);
      bit dec [0:199];
      bit ev  [0:199];
      int ecnt[0:199];
      bit eerr[0:199];
      bit prev, err;
      int run, cnt;
      prev = 1'b0; run = 0; cnt = 0; err = 1'b0;
      for (int i = 0; i < n; i++) begin
         dec[i] = (lv[i] == prev);
         prev   = lv[i];
      end
      for (int i = 0; i < n; i++) begin
         ev[i] = 1'b0;
         if (!err) begin
            if (run == ONES_MAX) begin
               if (dec[i]) err = 1'b1;
               else run = 0;
            end else begin
               ev[i] = 1'b1;
               run   = dec[i] ? run + 1 : 0;
               cnt   = (cnt < CNT_MAX) ? cnt + 1 : CNT_MAX;
            end
         end
         ecnt[i] = cnt;
         eerr[i] = err;
      end
      got = '0; ngot = 0;
      drive(1'b1, both, 1'b0, 1'b0);
      check("start_valid", {31'd0, out_valid}, 32'd0);
      check("start_end",   {31'd0, pkt_end},   32'd0);
      check("start_cnt",   {25'd0, bit_count}, 32'd0);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, lv[i], 1'b0);
         check("valid", {31'd0, out_valid},   {31'd0, ev[i]});
         if (ev[i] && out_valid) begin
            check("bit", {31'd0, out_bit}, {31'd0, dec[i]});
            got[ngot] = out_bit;
            ngot++;
         end
         check("cnt",  {25'd0, bit_count},   ecnt[i]);
         check("serr", {31'd0, stuff_error}, {31'd0, eerr[i]});
      end
      last_err = err;
      if (do_end) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         check("end_pkt",   {31'd0, pkt_end},     {31'd0, !err});
         check("end_valid", {31'd0, out_valid},   32'd0);
         check("end_cnt",   {25'd0, bit_count},   cnt);
         check("end_serr",  {31'd0, stuff_error}, {31'd0, err});
      end
   endtask

   initial begin
      int bias;
      #12;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check("idle_end_ignored", {31'd0, pkt_end}, 32'd0);

      // ACK handshake
      load(8, 200'h1B);
      run_packet(1'b0, 1'b1);
      check("ack_n",   ngot, 8);
      check("ack_pid", {24'd0, got[7:0]}, 32'hD2);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("ack_pkt_end_once", {31'd0, pkt_end}, 32'd0);

      // stuff removal
      load(8, 200'hC0);
      run_packet(1'b0, 1'b1);
      check("stuff_n",    ngot, 7);
      check("stuff_bits", {25'd0, got[6:0]}, 32'h7F);

      // stuff violation, sticky through end until abort
      load(7, 200'h00);
      run_packet(1'b0, 1'b1);
      check("viol_n", ngot, 6);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("viol_start_ignored", {31'd0, stuff_error}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check_zero("viol_abort");

      // abort mid-packet, then a fresh ACK
      load(8, 200'h1B);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, lv[i], 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      check_zero("abort_mid");
      run_packet(1'b0, 1'b1);
      check("abort_ack_pid", {24'd0, got[7:0]}, 32'hD2);

      // back-to-back packets
      run_packet(1'b0, 1'b1);
      run_packet(1'b0, 1'b1);
      check("b2b_pid", {24'd0, got[7:0]}, 32'hD2);

      // restart mid-packet, then start+end together restarting again
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, lv[i], 1'b0);
      run_packet(1'b0, 1'b0);
      run_packet(1'b1, 1'b1);
      check("restart_pid", {24'd0, got[7:0]}, 32'hD2);

      // bit_count saturation on a long all-transition packet
      n = 150;
      for (int i = 0; i < n; i++) lv[i] = (i % 2 == 0);
      run_packet(1'b0, 1'b1);
      check("sat_cnt", {25'd0, bit_count}, CNT_MAX);

      // asynchronous reset mid-packet
      load(8, 200'h1B);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, lv[i], 1'b0);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         check("post_rst_valid", {31'd0, out_valid}, 32'd0);
      end
      run_packet(1'b0, 1'b1);
      check("post_rst_pid", {24'd0, got[7:0]}, 32'hD2);

      // randomized packets against the reference
      for (int p = 0; p < 40; p++) begin
         n    = $urandom_range(1, 60);
         bias = $urandom_range(1, 5);
         lv[0] = 1'($urandom_range(0, 1));
         for (int i = 1; i < n; i++)
            lv[i] = ($urandom_range(0, bias) == 0) ? ~lv[i-1] : lv[i-1];
         run_packet(1'b0, 1'b1);
         if (last_err) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            check("rand_abort_serr", {31'd0, stuff_error}, 32'd0);
         end else if ($urandom_range(0, 1) == 1) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rc_nrzi_unstuff.md
# rc_nrzi_unstuff

Receive-path stage directly downstream of the D+/D- line decoder. It consumes the serial level stream (`s_in`, 1 = J, 0 = K) together with the start/end strobes, NRZI-decodes it, and removes USB stuffed bits. It delivers a clean bit stream, an end-of-packet pulse and a delivered-bit count to the CRC/PID checking stage. Stuffing violations are reported to the protocol FSM.

## Interface
- `ONES_MAX`, default 6: number of consecutive decoded 1s after which the next bit is a stuffed bit.
- `CNT_W`, default 7: width of `bit_count`.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `s_in` input 1: line level from the decoder (1 = J, 0 = K). Meaningful only in packet cycles.
- `start_rc_nrzi` input 1: one-cycle pulse on the final sync K. This cycle carries no data bit.
- `end_rc_nrzi` input 1: one-cycle pulse marking packet end. This cycle carries no data bit.
- `abort` input 1: synchronous reset. Has priority over all other inputs.
- `out_bit` output 1: decoded, unstuffed data bit.
- `out_valid` output 1: `out_bit` qualifier.
- `pkt_end` output 1: one-cycle pulse after a packet ends normally.
- `bit_count` output CNT_W: number of delivered bits in the current or last packet.
- `stuff_error` output 1: sticky stuffing-violation flag.

## Operation
- Registers: `prev_level`, `ones` (3 bits), `bit_count`, FSM state.
- State `IDLE`:
  - On `start_rc_nrzi`: go to `RX`; `prev_level <= 0` (sync ends in K); `ones <= 0`; `bit_count <= 0`.
  - All other inputs are ignored.
- State `RX`, one data bit per cycle unless `end_rc_nrzi` or `start_rc_nrzi` is high:
  - Decode: `d = ~(s_in ^ prev_level)`, meaning no transition = 1. Then `prev_level <= s_in`.
  - If `ones < ONES_MAX`: deliver `d`. `ones <= d ? ones+1 : 0`. `bit_count` increments, saturating at 2^CNT_W-1.
  - If `ones == ONES_MAX` and `d == 0`: stuffed bit. It is dropped (no `out_valid`), `ones <= 0`, and `bit_count` is unchanged.
  - If `ones == ONES_MAX` and `d == 1`: violation. Go to `ERROR`, `stuff_error <= 1`, and the bit is not delivered.
  - On `end_rc_nrzi`: go to `IDLE` and pulse `pkt_end`. If a stuffed bit was owed (`ones == ONES_MAX`), this is not an error.
  - On `start_rc_nrzi`: restart exactly as from `IDLE`. No `pkt_end` is issued.
- State `ERROR`:
  - `stuff_error` is held at 1. `out_valid` and `pkt_end` stay 0.
  - `start_rc_nrzi` and `end_rc_nrzi` are ignored.
  - Only `abort` or reset returns the block to `IDLE`.
- `abort` in any state: go to `IDLE`. All outputs and counters go to 0 on the next edge.
- `start_rc_nrzi` and `end_rc_nrzi` high in the same cycle: `start_rc_nrzi` wins.

## Timing
- Reset values: `out_bit`=0, `out_valid`=0, `pkt_end`=0, `bit_count`=0, `stuff_error`=0, state `IDLE`, `prev_level`=0, `ones`=0.
- All outputs are registered.
- A data bit on `s_in` at edge n appears as `out_bit`/`out_valid` at edge n+1.
- `end_rc_nrzi` at edge e produces `pkt_end` at edge e+1. The final `bit_count` is valid in that same cycle.
- `bit_count` holds until the next `start_rc_nrzi` or `abort`.
- `stuff_error` rises at the edge after the violating bit.
- `out_valid` is never high in the `pkt_end` cycle, the start cycle, or while in `ERROR`.
- Back-to-back packets are supported: `start_rc_nrzi` is accepted in the cycle immediately after `end_rc_nrzi`.

## Test plan
- **ACK handshake:** start, then `s_in` = 1,1,0,1,1,0,0,0, then end. Require `out_bit` = 0,1,0,0,1,0,1,1 (PID 0xD2, LSB first) on 8 consecutive `out_valid` cycles, `pkt_end` one cycle after end, `bit_count`=8, `stuff_error`=0.
- **Stuff removal:** start, then `s_in` = 0,0,0,0,0,0,1,1, then end. Require six 1s delivered, the stuffed bit dropped with a one-cycle `out_valid` gap, then `out_bit`=1 for the last bit, and `bit_count`=7.
- **Stuff violation:** start, then seven cycles of `s_in`=0. Require six 1s delivered, then `stuff_error`=1 one cycle after the 7th bit. It stays 1 through a later `end_rc_nrzi` with no `pkt_end`, and clears only after `abort`.
- **Abort mid-packet:** start, 4 bits, then `abort`. Next cycle all outputs are 0 and the state is `IDLE`. A fresh ACK packet then decodes correctly.
- **Back-to-back and restart:** two ACK packets with start in the cycle after end. Both decode, with two `pkt_end` pulses and `bit_count`=8 each. A `start_rc_nrzi` mid-packet restarts the count with no `pkt_end`.
- **Reset mid-packet:** assert `rst_n`=0 asynchronously between edges. All outputs drop to 0 immediately, with no `out_valid` after release until a new start.
